// File: rtl/tag_sort_pkg.sv
// Shared widths and payload helpers for the multibit-tree tag sorter stages.
`timescale 1ns/1ps
package tag_sort_pkg;

    localparam int INC_TAG_W_DEF   = 12;
    localparam int MATCH_TAG_W_DEF = 8;

    // Payload is {incoming, match, match_bak} packed into one vector.
    function automatic int payload_w(input int inc_w, input int match_w);
        return inc_w + 2 * match_w;
    endfunction

    localparam int PAYLOAD_W_DEF = payload_w(INC_TAG_W_DEF, MATCH_TAG_W_DEF);

endpackage

// File: rtl/tag_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
`timescale 1ns/1ps
module tag_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    // Count enabled cycles, never wrapping past the maximum.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tag_pipe_stage.sv
// Elastic valid/ready stage carrying the three sorter tags as one payload,
// with optional skid buffer, synchronous flush and a stall counter.
`timescale 1ns/1ps
module tag_pipe_stage
    import tag_sort_pkg::*;
#(
    parameter int INC_TAG_W   = INC_TAG_W_DEF,
    parameter int MATCH_TAG_W = MATCH_TAG_W_DEF,
    parameter int SKID        = 1,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INC_TAG_W-1:0]   in_incoming_tag,
    input  logic [MATCH_TAG_W-1:0] in_match_tag,
    input  logic [MATCH_TAG_W-1:0] in_match_tag_bak,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INC_TAG_W-1:0]   out_incoming_tag,
    output logic [MATCH_TAG_W-1:0] out_match_tag,
    output logic [MATCH_TAG_W-1:0] out_match_tag_bak,
    output logic [CNT_W-1:0]       stall_cnt
);

    localparam int PW = payload_w(INC_TAG_W, MATCH_TAG_W);

    logic [PW-1:0] in_data;
    logic [PW-1:0] main_data;
    logic          main_valid;
    logic          xfer_in;
    logic          xfer_out;

    assign in_data  = {in_incoming_tag, in_match_tag, in_match_tag_bak};
    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = main_valid && out_ready;

    // ---- main register stage -> downstream ----
    assign out_valid         = main_valid;
    assign out_incoming_tag  = main_data[PW-1 -: INC_TAG_W];
    assign out_match_tag     = main_data[2*MATCH_TAG_W-1 -: MATCH_TAG_W];
    assign out_match_tag_bak = main_data[MATCH_TAG_W-1:0];

    if (SKID != 0) begin : g_skid
        logic          skid_valid;
        logic [PW-1:0] skid_data;
        logic          main_free;

        // Registered ready: only the skid occupancy gates acceptance.
        assign in_ready  = !skid_valid && !rst && !flush;
        assign main_free = !main_valid || out_ready;

        // Main refills from skid first to keep FIFO order; otherwise from input.
        always_ff @(posedge clk) begin
            if (rst) begin
                main_valid <= 1'b0;
                main_data  <= '0;
                skid_valid <= 1'b0;
                skid_data  <= '0;
            end else if (flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (main_free) begin
                if (skid_valid) begin
                    main_valid <= 1'b1;
                    main_data  <= skid_data;
                    skid_valid <= 1'b0;
                end else if (xfer_in) begin
                    main_valid <= 1'b1;
                    main_data  <= in_data;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (xfer_in) begin
                // Accepted while main is stalled: park in skid.
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end
        end
    end else begin : g_reg
        // Combinational ready: downstream acceptance frees the register.
        assign in_ready = (!main_valid || out_ready) && !rst && !flush;

        // Single register: load on accept, empty on an unreplaced drain.
        always_ff @(posedge clk) begin
            if (rst) begin
                main_valid <= 1'b0;
                main_data  <= '0;
            end else if (flush) begin
                main_valid <= 1'b0;
            end else if (xfer_in) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
            end else if (xfer_out) begin
                main_valid <= 1'b0;
            end
        end
    end

    tag_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .en  (main_valid && !out_ready),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_tag_pipe_stage.sv
// Directed bench for tag_pipe_stage: reset, streaming in both modes,
// backpressure, flush, counter saturation and a narrow-field scoreboard run.
`timescale 1ns/1ps
module tb_tag_pipe_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Shared stimulus for instances A (SKID=1) and B (SKID=0)
    logic        rst, flush, in_valid, out_ready;
    logic [11:0] in_inc;
    logic [7:0]  in_m, in_b;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [11:0] a_inc, b_inc;
    logic [7:0]  a_m, a_b, b_m, b_b;
    logic [15:0] a_stall, b_stall;

    // Instance C: saturation with CNT_W=3
    logic        c_in_valid, c_out_ready, c_in_ready, c_out_valid;
    logic [11:0] c_in_inc, c_inc;
    logic [7:0]  c_in_m, c_in_b, c_m, c_b;
    logic [2:0]  c_stall;

    // Instance D: INC_TAG_W=20, MATCH_TAG_W=1
    logic        d_in_valid, d_out_ready, d_in_ready, d_out_valid;
    logic [19:0] d_in_inc, d_inc;
    logic [0:0]  d_in_m, d_in_b, d_m, d_b;
    logic [15:0] d_stall;

    tag_pipe_stage #(.SKID(1)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_incoming_tag(in_inc), .in_match_tag(in_m), .in_match_tag_bak(in_b),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_incoming_tag(a_inc),
        .out_match_tag(a_m), .out_match_tag_bak(a_b), .stall_cnt(a_stall));

    tag_pipe_stage #(.SKID(0)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_incoming_tag(in_inc), .in_match_tag(in_m), .in_match_tag_bak(in_b),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_incoming_tag(b_inc),
        .out_match_tag(b_m), .out_match_tag_bak(b_b), .stall_cnt(b_stall));

    tag_pipe_stage #(.SKID(1), .CNT_W(3)) u_c (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_incoming_tag(c_in_inc), .in_match_tag(c_in_m), .in_match_tag_bak(c_in_b),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_incoming_tag(c_inc),
        .out_match_tag(c_m), .out_match_tag_bak(c_b), .stall_cnt(c_stall));

    tag_pipe_stage #(.INC_TAG_W(20), .MATCH_TAG_W(1), .SKID(1)) u_d (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_incoming_tag(d_in_inc), .in_match_tag(d_in_m), .in_match_tag_bak(d_in_b),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_incoming_tag(d_inc),
        .out_match_tag(d_m), .out_match_tag_bak(d_b), .stall_cnt(d_stall));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [11:0] t, input logic r);
        in_valid  = v;
        in_inc    = t;
        in_m      = t[7:0] ^ 8'h5A;
        in_b      = t[7:0] ^ 8'hC3;
        out_ready = r;
    endtask

    task automatic chk_a(input string tag, input logic [11:0] t);
        logic [7:0] lo;
        lo = t[7:0];
        chk({tag, "_a_vld"}, 64'(a_out_valid), 64'(1));
        chk({tag, "_a_inc"}, 64'(a_inc), 64'(t));
        chk({tag, "_a_m"},   64'(a_m),   64'(lo ^ 8'h5A));
        chk({tag, "_a_b"},   64'(a_b),   64'(lo ^ 8'hC3));
    endtask

    logic [21:0] q[$];
    logic [21:0] exp_d;
    int          exp_sat;

    initial begin
        flush = 1'b0;
        c_in_valid = 1'b0; c_out_ready = 1'b0;
        c_in_inc = 12'h7E1; c_in_m = 8'h3C; c_in_b = 8'h96;
        d_in_valid = 1'b0; d_out_ready = 1'b0;
        d_in_inc = '0; d_in_m = '0; d_in_b = '0;

        // Reset held 3 cycles with an offered entry
        rst = 1'b1;
        drv(1'b1, 12'h05A, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_a_vld",   64'(a_out_valid), 64'(0));
            chk("rst_a_inc",   64'(a_inc),       64'(0));
            chk("rst_a_m",     64'(a_m),         64'(0));
            chk("rst_a_b",     64'(a_b),         64'(0));
            chk("rst_a_stall", 64'(a_stall),     64'(0));
            chk("rst_a_rdy",   64'(a_in_ready),  64'(0));
            chk("rst_b_vld",   64'(b_out_valid), 64'(0));
            chk("rst_b_rdy",   64'(b_in_ready),  64'(0));
        end
        rst = 1'b0;
        drv(1'b0, 12'h000, 1'b1);
        #1;
        chk("post_rst_a_rdy", 64'(a_in_ready), 64'(1));
        chk("post_rst_b_rdy", 64'(b_in_ready), 64'(1));

        // Back-to-back streaming with out_ready=1
        for (int i = 1; i <= 16; i++) begin
            drv(1'b1, 12'(i), 1'b1);
            #1;
            chk("str_a_rdy", 64'(a_in_ready), 64'(1));
            chk("str_b_rdy", 64'(b_in_ready), 64'(1));
            step();
            chk_a("str", 12'(i));
            chk("str_b_vld", 64'(b_out_valid), 64'(1));
            chk("str_b_inc", 64'(b_inc), 64'(i));
            chk("str_b_m",   64'(b_m),   64'(8'(i) ^ 8'h5A));
        end
        drv(1'b0, 12'h000, 1'b1);
        step();
        chk("str_end_a_vld", 64'(a_out_valid), 64'(0));
        chk("str_end_b_vld", 64'(b_out_valid), 64'(0));
        chk("str_a_stall",   64'(a_stall),     64'(0));

        // Backpressure on the skid variant
        drv(1'b1, 12'h021, 1'b1);
        step();
        chk_a("bp_load", 12'h021);
        drv(1'b1, 12'h022, 1'b0);
        #1;
        chk("bp1_a_rdy", 64'(a_in_ready), 64'(1));
        chk("bp1_b_rdy", 64'(b_in_ready), 64'(0));
        step();
        chk("bp1_stall", 64'(a_stall), 64'(1));
        chk_a("bp1_hold", 12'h021);
        drv(1'b1, 12'h023, 1'b0);
        for (int k = 2; k <= 4; k++) begin
            #1;
            chk("bp_a_rdy", 64'(a_in_ready), 64'(0));
            step();
            chk("bp_stall", 64'(a_stall), 64'(k));
            chk_a("bp_hold", 12'h021);
        end
        drv(1'b1, 12'h023, 1'b1);
        #1;
        chk("rel_a_rdy", 64'(a_in_ready), 64'(0));
        step();
        chk_a("rel_skid", 12'h022);
        chk("rel_stall", 64'(a_stall), 64'(4));
        #1;
        chk("rel2_a_rdy", 64'(a_in_ready), 64'(1));
        step();
        chk_a("rel_next", 12'h023);

        // Fill main+skid, then flush with an entry offered
        drv(1'b1, 12'h024, 1'b0);
        step();
        chk("fill_stall", 64'(a_stall), 64'(5));
        chk("fill_a_rdy", 64'(a_in_ready), 64'(0));
        flush = 1'b1;
        drv(1'b1, 12'h025, 1'b1);
        #1;
        chk("fl_a_rdy", 64'(a_in_ready), 64'(0));
        chk("fl_b_rdy", 64'(b_in_ready), 64'(0));
        step();
        flush = 1'b0;
        drv(1'b0, 12'h000, 1'b0);
        chk("fl_a_vld",   64'(a_out_valid), 64'(0));
        chk("fl_b_vld",   64'(b_out_valid), 64'(0));
        chk("fl_stall",   64'(a_stall),     64'(5));
        chk("fl_inc_hld", 64'(a_inc),       64'(12'h023));
        #1;
        chk("fl_skid_empty_rdy", 64'(a_in_ready), 64'(1));
        step();
        chk("fl_stall2", 64'(a_stall), 64'(5));
        drv(1'b1, 12'h026, 1'b1);
        step();
        chk_a("fl_after", 12'h026);
        drv(1'b0, 12'h000, 1'b1);
        step();
        chk("fl_drained", 64'(a_out_valid), 64'(0));

        // Stall counter saturation at 7 with CNT_W=3
        c_in_valid = 1'b1;
        step();
        c_in_valid = 1'b0;
        chk("sat_c_vld", 64'(c_out_valid), 64'(1));
        chk("sat_c_inc", 64'(c_inc), 64'(12'h7E1));
        chk("sat_c_0",   64'(c_stall), 64'(0));
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_sat = (k > 7) ? 7 : k;
            chk("sat_c_cnt", 64'(c_stall), 64'(exp_sat));
        end

        // Narrow-field random traffic against a FIFO scoreboard
        for (int n = 0; n < 400; n++) begin
            d_in_valid  = 1'($urandom_range(0, 1));
            d_out_ready = ($urandom_range(0, 3) != 0);
            d_in_inc    = 20'($urandom);
            d_in_m      = 1'($urandom);
            d_in_b      = 1'($urandom);
            #1;
            if (d_in_valid && d_in_ready) q.push_back({d_in_inc, d_in_m, d_in_b});
            if (d_out_valid && d_out_ready) begin
                if (q.size() == 0) begin
                    chk("d_dup", 64'(1), 64'(0));
                end else begin
                    exp_d = q.pop_front();
                    chk("d_data", 64'({d_inc, d_m, d_b}), 64'(exp_d));
                end
            end
            step();
        end
        d_in_valid  = 1'b0;
        d_out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            #1;
            if (d_out_valid && d_out_ready) begin
                if (q.size() == 0) begin
                    chk("d_dup", 64'(1), 64'(0));
                end else begin
                    exp_d = q.pop_front();
                    chk("d_data", 64'({d_inc, d_m, d_b}), 64'(exp_d));
                end
            end
            step();
        end
        chk("d_lost", 64'(q.size()), 64'(0));
        chk("d_idle", 64'(d_out_valid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
